fp16_operand_loader: RTL and testbench

FP16_OPERAND_LOADER -- requirements
Module: fp16_operand_loader

---
 rtl/fp16_operand_loader_if.sv | 24 ++
 rtl/fp16_operand_loader.sv | 179 +++++++++++++++++
 tb/tb_fp16_operand_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fp16_operand_loader_if.sv
// Byte-beat input and FP16 operand-pair output handshake for fp16_operand_loader.
// master = upstream byte source / downstream multiplier side, slave = the loader.
interface fp16_operand_loader_if;
   logic        byte_valid;
   logic        byte_sof;
   logic [7:0]  a_byte;
   logic [7:0]  b_byte;
   logic        byte_ready;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [5:0]  op_flags;

   modport master (
      output byte_valid, byte_sof, a_byte, b_byte, op_ready,
      input  byte_ready, op_valid, op_a, op_b, op_flags
   );

   modport slave (
      input  byte_valid, byte_sof, a_byte, b_byte, op_ready,
      output byte_ready, op_valid, op_a, op_b, op_flags
   );
endinterface

// File: rtl/fp16_operand_loader.sv
// Assembles FP16 operand pairs from two byte beats, classifies them and queues them in a 2-entry FIFO.
// Optional macro FP16_FTZ_EN flushes subnormal operands to signed zero.
module fp16_operand_loader #(
   parameter int LOW_FIRST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   fp16_operand_loader_if.slave  bus,
   output logic [1:0]            fifo_count,
   output logic                  frame_err
);

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } phase_t;

   typedef struct packed {
      logic [5:0]  flags;
      logic [15:0] a;
      logic [15:0] b;
   } entry_t;

   phase_t      phase_q;
   phase_t      phase_d;
   logic [7:0]  hold_a;
   logic [7:0]  hold_b;
   logic        err_q;

   entry_t      mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count_q;

   logic        ready_int;
   logic        accept;
   logic        latch_first;
   logic        push;
   logic        pop;
   logic        set_err;

   logic [15:0] raw_a;
   logic [15:0] raw_b;
   logic [18:0] cls_a;
   logic [18:0] cls_b;
   entry_t      new_entry;
   entry_t      head;

   // Returns {nan, inf, zero, value}; the value differs from raw only when subnormals are flushed.
   function automatic logic [18:0] classify(input logic [15:0] raw);
      logic [4:0]  e;
      logic [9:0]  m;
      logic [15:0] v;
      logic        is_nan;
      logic        is_inf;
      logic        is_zero;
      e       = raw[14:10];
      m       = raw[9:0];
      v       = raw;
      is_nan  = (e == 5'd31) && (m != 10'd0);
      is_inf  = (e == 5'd31) && (m == 10'd0);
      is_zero = (e == 5'd0)  && (m == 10'd0);
`ifdef FP16_FTZ_EN
      if ((e == 5'd0) && (m != 10'd0)) begin
         v       = {raw[15], 15'b0};
         is_zero = 1'b1;
      end
`endif
      return {is_nan, is_inf, is_zero, v};
   endfunction

   always_comb begin
      phase_d     = phase_q;
      ready_int   = 1'b0;
      latch_first = 1'b0;
      push        = 1'b0;
      set_err     = 1'b0;
      accept      = 1'b0;
      if (!rst) begin
         case (phase_q)
            FIRST: begin
               ready_int = 1'b1;
               accept    = bus.byte_valid;
               if (accept) begin
                  latch_first = 1'b1;
                  phase_d     = SECOND;
               end
            end
            SECOND: begin
               ready_int = (count_q < 2'd2) || bus.op_ready;
               accept    = bus.byte_valid && ready_int;
               if (accept) begin
                  if (bus.byte_sof) begin
                     // A new frame start restarts the pair; the stale first bytes are dropped.
                     latch_first = 1'b1;
                     set_err     = 1'b1;
                  end else begin
                     push    = 1'b1;
                     phase_d = FIRST;
                  end
               end
            end
            default: phase_d = FIRST;
         endcase
      end
   end

   always_comb begin
      if (LOW_FIRST != 0) begin
         raw_a = {bus.a_byte, hold_a};
         raw_b = {bus.b_byte, hold_b};
      end else begin
         raw_a = {hold_a, bus.a_byte};
         raw_b = {hold_b, bus.b_byte};
      end
      cls_a           = classify(raw_a);
      cls_b           = classify(raw_b);
      new_entry.flags = {cls_a[18:16], cls_b[18:16]};
      new_entry.a     = cls_a[15:0];
      new_entry.b     = cls_b[15:0];
   end

   assign pop = (count_q != 2'd0) && bus.op_ready && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= FIRST;
         hold_a  <= 8'd0;
         hold_b  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         if (latch_first) begin
            hold_a <= bus.a_byte;
            hold_b <= bus.b_byte;
         end
         if (set_err) begin
            err_q <= 1'b1;
         end
      end
   end

   // At count 2 a push is only possible together with a pop, so writing the slot
   // under wr_ptr (== rd_ptr) overwrites the entry leaving the head this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head = mem[rd_ptr];

   assign bus.byte_ready = ready_int;
   assign bus.op_valid   = !rst && (count_q != 2'd0);
   assign bus.op_a       = rst ? 16'd0 : head.a;
   assign bus.op_b       = rst ? 16'd0 : head.b;
   assign bus.op_flags   = rst ? 6'd0 : head.flags;
   assign fifo_count     = rst ? 2'd0 : count_q;
   assign frame_err      = rst ? 1'b0 : err_q;

endmodule

// File: tb/tb_fp16_operand_loader.sv
// Directed self-checking bench for fp16_operand_loader (default LOW_FIRST = 1).
// Expected values are hand-computed; FTZ expectations follow FP16_FTZ_EN.
module tb_fp16_operand_loader;

   logic       clk;
   logic       rst;
   logic [1:0] fifo_count;
   logic       frame_err;
   int         compareCount;
   int         failCount;

   fp16_operand_loader_if bus ();

   fp16_operand_loader #(.LOW_FIRST(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fifo_count (fifo_count),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic sof, input logic [7:0] a, input logic [7:0] b);
      bus.byte_valid = valid;
      bus.byte_sof   = sof;
      bus.a_byte     = a;
      bus.b_byte     = b;
   endtask

   // Presents one beat, waits (bounded) for byte_ready, then lets it be accepted.
   task automatic sendBeat(input logic sof, input logic [7:0] a, input logic [7:0] b);
      int waited;
      applyStimulus(1'b1, sof, a, b);
      #1;
      waited = 0;
      while (!bus.byte_ready && waited < 20) begin
         step();
         waited++;
      end
      if (!bus.byte_ready) begin
         checkOutput("beat_timeout", 32'd0, 32'd1);
      end else begin
         step();
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic popPair(input string tag, input logic [15:0] expA, input logic [15:0] expB, input logic [5:0] expFlags);
      checkOutput({tag, "_valid"}, {31'd0, bus.op_valid}, 32'd1);
      checkOutput({tag, "_a"}, {16'd0, bus.op_a}, {16'd0, expA});
      checkOutput({tag, "_b"}, {16'd0, bus.op_b}, {16'd0, expB});
      checkOutput({tag, "_flags"}, {26'd0, bus.op_flags}, {26'd0, expFlags});
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
   endtask

   initial begin
      compareCount = 0;
      failCount    = 0;
      rst          = 1'b1;
      bus.op_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      #2;
      checkOutput("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
      checkOutput("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
      checkOutput("rst_count", {30'd0, fifo_count}, 32'd0);
      checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      checkOutput("idle_byte_ready", {31'd0, bus.byte_ready}, 32'd1);
      checkOutput("idle_op_a", {16'd0, bus.op_a}, 32'd0);

      // Basic pair with one-cycle latency.
      sendBeat(1'b1, 8'h00, 8'h00);
      checkOutput("basic_mid_valid", {31'd0, bus.op_valid}, 32'd0);
      sendBeat(1'b0, 8'h3E, 8'h42);
      checkOutput("basic_count", {30'd0, fifo_count}, 32'd1);
      popPair("basic", 16'h3E00, 16'h4200, 6'b000_000);
      checkOutput("basic_empty", {31'd0, bus.op_valid}, 32'd0);

      // Backpressure: fill to two, stall the third pair, then push with a simultaneous pop.
      sendBeat(1'b0, 8'h00, 8'h00);
      sendBeat(1'b0, 8'h3C, 8'h40);
      sendBeat(1'b0, 8'h00, 8'h00);
      sendBeat(1'b0, 8'h44, 8'h48);
      checkOutput("full_count", {30'd0, fifo_count}, 32'd2);
      sendBeat(1'b0, 8'h00, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h4C, 8'h50);
      #1;
      checkOutput("full_ready_low", {31'd0, bus.byte_ready}, 32'd0);
      step();
      checkOutput("stall_ready_low", {31'd0, bus.byte_ready}, 32'd0);
      checkOutput("stall_count", {30'd0, fifo_count}, 32'd2);
      checkOutput("stall_head_a", {16'd0, bus.op_a}, 32'h3C00);
      bus.op_ready = 1'b1;
      #1;
      checkOutput("unstall_ready", {31'd0, bus.byte_ready}, 32'd1);
      step();
      bus.op_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      checkOutput("pushpop_count", {30'd0, fifo_count}, 32'd2);
      popPair("fifo_p2", 16'h4400, 16'h4800, 6'b000_000);
      checkOutput("after_p2_count", {30'd0, fifo_count}, 32'd1);
      popPair("fifo_p3", 16'h4C00, 16'h5000, 6'b000_000);
      checkOutput("drained_count", {30'd0, fifo_count}, 32'd0);

      // Classification: A inf, B nan; then A negative zero.
      sendBeat(1'b0, 8'h00, 8'h01);
      sendBeat(1'b0, 8'h7C, 8'h7E);
      popPair("cls_infnan", 16'h7C00, 16'h7E01, 6'b010_100);
      sendBeat(1'b0, 8'h00, 8'h00);
      sendBeat(1'b0, 8'h80, 8'h3C);
      popPair("cls_negzero", 16'h8000, 16'h3C00, 6'b001_000);

      // Framing error: a second start-of-frame replaces the held first bytes.
      checkOutput("pre_frame_err", {31'd0, frame_err}, 32'd0);
      sendBeat(1'b1, 8'h11, 8'h22);
      sendBeat(1'b1, 8'h00, 8'h00);
      checkOutput("frame_err_set", {31'd0, frame_err}, 32'd1);
      checkOutput("frame_no_push", {30'd0, fifo_count}, 32'd0);
      sendBeat(1'b0, 8'h3C, 8'h40);
      checkOutput("frame_err_sticky", {31'd0, frame_err}, 32'd1);
      popPair("frame_pair", 16'h3C00, 16'h4000, 6'b000_000);

      // Subnormals: A = 0001, B = 8001.
      sendBeat(1'b0, 8'h01, 8'h01);
      sendBeat(1'b0, 8'h00, 8'h80);
`ifdef FP16_FTZ_EN
      popPair("subnormal", 16'h0000, 16'h8000, 6'b001_001);
`else
      popPair("subnormal", 16'h0001, 16'h8001, 6'b000_000);
`endif

      // Reset mid-pair with a queued entry present.
      sendBeat(1'b0, 8'h00, 8'h00);
      sendBeat(1'b0, 8'h40, 8'h40);
      sendBeat(1'b0, 8'hAA, 8'hBB);
      checkOutput("prereset_count", {30'd0, fifo_count}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
      checkOutput("midrst_valid", {31'd0, bus.op_valid}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      checkOutput("postrst_count", {30'd0, fifo_count}, 32'd0);
      checkOutput("postrst_valid", {31'd0, bus.op_valid}, 32'd0);
      checkOutput("postrst_frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("postrst_ready", {31'd0, bus.byte_ready}, 32'd1);
      sendBeat(1'b0, 8'h00, 8'h00);
      sendBeat(1'b0, 8'h3C, 8'hC0);
      popPair("fresh_pair", 16'h3C00, 16'hC000, 6'b000_000);
      checkOutput("fresh_frame_err", {31'd0, frame_err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
